// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared op codes, FSM states and saturation constants for accum_8bit_v
package accum_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/addn_sub_8bit_v.sv
// rtl/addn_sub_8bit_v.sv - 8-bit ripple add/subtract datapath, C is carry on add and borrow on subtract
module addn_sub_8bit_v (
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic       i_MODE,
  output logic [7:0] o_S,
  output logic       o_C
);

  logic [8:0] carry;
  logic [7:0] b_x;

  // Ripple chain: subtract is A + ~B + 1, and the raw carry-out is inverted into a borrow
  always_comb begin
    carry    = 9'd0;
    b_x      = 8'd0;
    o_S      = 8'd0;
    carry[0] = i_MODE;
    for (int i = 0; i < 8; i++) begin
      b_x[i]       = i_B[i] ^ i_MODE;
      o_S[i]       = i_A[i] ^ b_x[i] ^ carry[i];
      carry[i + 1] = (i_A[i] & b_x[i]) | (carry[i] & (i_A[i] ^ b_x[i]));
    end
    o_C = carry[8] ^ i_MODE;
  end

endmodule

// File: rtl/accum_8bit_v.sv
// rtl/accum_8bit_v.sv - handshaked 8-bit accumulator with flags and op counter; ACCUM_SAT_EN enables signed saturation
module accum_8bit_v
  import accum_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [1:0]       i_OP,
  input  logic [7:0]       i_DATA,
  output logic [7:0]       o_ACC,
  output logic             o_C,
  output logic             o_V,
  output logic             o_Z,
  output logic             o_N,
  output logic             o_DONE,
  output logic [CNT_W-1:0] o_CNT
);

  state_e           state_q;
  op_e              op_q;
  logic [7:0]       data_q;
  logic [7:0]       acc_q;
  logic             c_q, v_q, z_q, n_q;
  logic             done_q, ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic       sub_mode;
  logic [7:0] add_s;
  logic       add_c;
  logic [7:0] b_eff;
  logic       ovf;
  logic [7:0] acc_d;
  logic       c_d, v_d;

  assign sub_mode = (op_q == OP_SUB);

  addn_sub_8bit_v u_addsub (
    .i_A    (acc_q),
    .i_B    (data_q),
    .i_MODE (sub_mode),
    .o_S    (add_s),
    .o_C    (add_c)
  );

  // Signed overflow: operands (after subtract inversion) agree in sign but the sum does not
  always_comb begin
    b_eff = sub_mode ? ~data_q : data_q;
    ovf   = (acc_q[7] == b_eff[7]) && (add_s[7] != acc_q[7]);
  end

  // Result selection for the EXEC cycle
  always_comb begin
    acc_d = acc_q;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      OP_LOAD: acc_d = data_q;
      OP_CLR:  acc_d = 8'h00;
      OP_ADD, OP_SUB: begin
        c_d = add_c;
        v_d = ovf;
`ifdef ACCUM_SAT_EN
        // Both effective operands share acc_q's sign on overflow, so it tells the direction
        if (ovf) acc_d = acc_q[7] ? SAT_NEG : SAT_POS;
        else     acc_d = add_s;
`else
        acc_d = add_s;
`endif
      end
      default: acc_d = acc_q;
    endcase
  end

  // Command FSM with registered outputs; reset discards any in-flight command
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= 8'h00;
      acc_q   <= 8'h00;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_VALID && ready_q) begin
            op_q    <= op_e'(i_OP);
            data_q  <= i_DATA;
            ready_q <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc_q   <= acc_d;
          c_q     <= c_d;
          v_q     <= v_d;
          z_q     <= (acc_d == 8'h00);
          n_q     <= acc_d[7];
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          cnt_q   <= cnt_q + CNT_W'(1);
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_READY = ready_q;
  assign o_ACC   = acc_q;
  assign o_C     = c_q;
  assign o_V     = v_q;
  assign o_Z     = z_q;
  assign o_N     = n_q;
  assign o_DONE  = done_q;
  assign o_CNT   = cnt_q;

endmodule

// File: tb/tb_accum_8bit_v.sv
// tb/tb_accum_8bit_v.sv - self-checking bench for accum_8bit_v (vectors, random model, handshake and reset cases)
module tb_accum_8bit_v;
  import accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] op;
  logic [7:0] data;
  logic       ready, c, v, z, n, done;
  logic [7:0] acc;
  logic [3:0] cnt;

  logic       ready2, c2, v2, z2, n2, done2;
  logic [7:0] acc2;
  logic [1:0] cnt2;

  int tests  = 0;
  int failed = 0;

  int m_acc, m_c, m_v, m_cnt;

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] acc;
    logic       c, v, z, n;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  accum_8bit_v #(.CNT_W(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .o_READY(ready), .i_OP(op), .i_DATA(data),
    .o_ACC(acc), .o_C(c), .o_V(v), .o_Z(z), .o_N(n), .o_DONE(done), .o_CNT(cnt)
  );

  accum_8bit_v #(.CNT_W(2)) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .o_READY(ready2), .i_OP(op), .i_DATA(data),
    .o_ACC(acc2), .o_C(c2), .o_V(v2), .o_Z(z2), .o_N(n2), .o_DONE(done2), .o_CNT(cnt2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on the command's meaning
  task automatic model_step(input logic [1:0] o, input logic [7:0] d);
    int a, b, r, sr;
    a = m_acc;
    b = int'(d);
    case (o)
      2'b00: begin m_acc = b; m_c = 0; m_v = 0; end
      2'b11: begin m_acc = 0; m_c = 0; m_v = 0; end
      default: begin
        if (o == 2'b01) begin
          r    = a + b;
          m_c  = (r > 255) ? 1 : 0;
          sr   = to_signed8(a) + to_signed8(b);
        end else begin
          r    = a - b;
          m_c  = (a < b) ? 1 : 0;
          sr   = to_signed8(a) - to_signed8(b);
        end
        m_v   = (sr > 127 || sr < -128) ? 1 : 0;
        m_acc = (r + 256) % 256;
`ifdef ACCUM_SAT_EN
        if (m_v == 1) m_acc = (sr > 127) ? 127 : 128;
`endif
      end
    endcase
    m_cnt = (m_cnt + 1) % 16;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_c"}, c, m_c);
    chk({tag, "_v"}, v, m_v);
    chk({tag, "_z"}, z, (m_acc == 0) ? 1 : 0);
    chk({tag, "_n"}, n, (m_acc >= 128) ? 1 : 0);
  endtask

  // Called and returning on a falling edge; accepts one command and follows it to IDLE
  task automatic run_cmd(input logic [1:0] o, input logic [7:0] d, input string tag);
    int waitn = 0;
    while (!ready && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    chk({tag, "_ready_idle"}, ready, 1);
    valid = 1'b1;
    op    = o;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
    chk({tag, "_ready_exec"}, ready, 0);
    chk({tag, "_done_exec"}, done, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_ready_done"}, ready, 0);
    model_step(o, d);
    check_flags(tag);
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_ready_back"}, ready, 1);
    chk({tag, "_cnt"}, cnt, m_cnt);
    chk({tag, "_cnt2"}, cnt2, m_cnt % 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_base, cnt_base;
    int accepts;
    tbl[0]  = '{2'b00, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ACCUM_SAT_EN
    tbl[1]  = '{2'b01, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    tbl[1]  = '{2'b01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    tbl[2]  = '{2'b00, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{2'b01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ACCUM_SAT_EN
    tbl[7]  = '{2'b10, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    tbl[7]  = '{2'b10, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    tbl[8]  = '{2'b11, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ACCUM_SAT_EN
    tbl[10] = '{2'b01, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    tbl[10] = '{2'b01, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    rst = 1'b1; valid = 1'b0; op = 2'b00; data = 8'h00;
    m_acc = 0; m_c = 0; m_v = 0; m_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_acc", acc, 0);
    chk("rst_c", c, 0);
    chk("rst_v", v, 0);
    chk("rst_z", z, 1);
    chk("rst_n", n, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", ready, 1);

    // Directed vectors (state carries from one row to the next)
    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].op, tbl[i].d, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_acc", i), acc, tbl[i].acc);
      chk($sformatf("vec%0d_tbl_c", i), c, tbl[i].c);
      chk($sformatf("vec%0d_tbl_v", i), v, tbl[i].v);
      chk($sformatf("vec%0d_tbl_z", i), z, tbl[i].z);
      chk($sformatf("vec%0d_tbl_n", i), n, tbl[i].n);
    end

    // Flags hold while idle
    repeat (4) @(negedge clk);
    check_flags("hold");

    // i_VALID held high: one accept every three cycles
    run_cmd(2'b00, 8'h10, "pre_stream");
    acc_base = m_acc;
    cnt_base = m_cnt;
    accepts  = 0;
    valid = 1'b1; op = 2'b01; data = 8'h01;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stream_ready%0d", i), ready, (i % 3 == 0) ? 1 : 0);
      chk($sformatf("stream_done%0d", i), done, (i % 3 == 2) ? 1 : 0);
      if (ready) accepts++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("stream_accepts", accepts, 4);
    for (int i = 0; i < 4; i++) model_step(2'b01, 8'h01);
    chk("stream_acc", acc, (acc_base + 4) % 256);
    chk("stream_cnt", cnt, (cnt_base + 4) % 16);
    chk("stream_cnt2", cnt2, (cnt_base + 4) % 4);
    check_flags("stream");

    // Randomized commands against the reference model
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
    end

    // Reset during EXEC discards the command
    run_cmd(2'b00, 8'h33, "pre_rst");
    valid = 1'b1; op = 2'b01; data = 8'h10;
    @(negedge clk);
    valid = 1'b0;
    chk("midrst_in_exec", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_c = 0; m_v = 0; m_cnt = 0;
    chk("midrst_acc", acc, 0);
    chk("midrst_z", z, 1);
    chk("midrst_ready", ready, 1);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_cnt2", cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst_nodone%0d", i), done, 0);
      @(negedge clk);
    end
    chk("midrst_cnt_after", cnt, 0);
    run_cmd(2'b01, 8'h22, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
